// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: scoreboard entries, exceptions, functional
// units and operations, plus the commit FSM state encoding.
package commit_unit_pkg;

  localparam int unsigned DEFAULT_NR_COMMIT_PORTS = 32'd2;
  localparam int unsigned XLEN                    = 32'd64;
  localparam int unsigned REG_ADDR_W              = 32'd5;

  typedef enum logic [3:0] {
    FU_NONE   = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6,
    FPU       = 4'd7
  } fu_t;

  typedef enum logic [6:0] {
    ADD       = 7'd0,
    SUB       = 7'd1,
    FENCE     = 7'd2,
    FENCE_I   = 7'd3,
    CSR_READ  = 7'd4,
    CSR_WRITE = 7'd5,
    LD        = 7'd6,
    SD        = 7'd7,
    FADD      = 7'd8,
    FMUL      = 7'd9,
    FMV_X2F   = 7'd10,
    FMV_F2X   = 7'd11
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic                  valid;
    fu_t                   fu;
    fu_op                  op;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       result;
    exception_t            ex;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FENCE_WAIT = 2'd1,
    EXC_WAIT   = 2'd2
  } commit_state_e;

  // Operations whose destination lives in the floating-point register file.
  function automatic logic is_rd_fpr(input fu_op op);
    case (op)
      FADD, FMUL, FMV_X2F: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Commit window from the scoreboard, register-file write ports and the store
// commit handshake to the LSU, bundled between scoreboard side and commit unit.
interface commit_unit_if
  import commit_unit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = DEFAULT_NR_COMMIT_PORTS
) ();

  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]                 commit_instr;
  logic              [NR_COMMIT_PORTS-1:0]                 commit_ack;
  logic              [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0] waddr;
  logic              [NR_COMMIT_PORTS-1:0][XLEN-1:0]       wdata;
  logic              [NR_COMMIT_PORTS-1:0]                 we_gpr;
  logic              [NR_COMMIT_PORTS-1:0]                 we_fpr;
  logic                                                    commit_lsu;
  logic                                                    commit_lsu_ready;
  logic                                                    no_st_pending;

  modport master (
    output commit_instr, commit_lsu_ready, no_st_pending,
    input  commit_ack, waddr, wdata, we_gpr, we_fpr, commit_lsu
  );

  modport slave (
    input  commit_instr, commit_lsu_ready, no_st_pending,
    output commit_ack, waddr, wdata, we_gpr, we_fpr, commit_lsu
  );

endinterface

// File: rtl/commit_unit.sv
// Retires up to two in-order scoreboard entries per cycle, writes the register
// files, grants store commits and sequences fences/exceptions.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = DEFAULT_NR_COMMIT_PORTS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              halt_i,
  input  logic              flush_i,
  commit_unit_if.slave      cu,
  output exception_t        exception_o,
  output logic              fence_flush_o,
  output logic [XLEN-1:0]   instret_o
);

  if (NR_COMMIT_PORTS != 32'd2) begin : g_bad_ports
    $fatal(1, "commit_unit supports only NR_COMMIT_PORTS = 2");
  end

  commit_state_e     state_q, state_d;
  exception_t        exception_q, exception_d;
  logic              fence_flush_q, fence_flush_d;
  logic [XLEN-1:0]   instret_q, instret_d;

  scoreboard_entry_t instr0_s, instr1_s;
  logic              head_go_s, head_exc_s, head_store_s, head_fence_s;
  logic              fence_release_s, port1_ok_s;
  logic [1:0]        ack_s, we_gpr_s, we_fpr_s;
  logic              commit_lsu_s;
  logic              unused_s;

  assign instr0_s = cu.commit_instr[0];
  assign instr1_s = cu.commit_instr[1];
  assign unused_s = ^{instr1_s.ex.cause, instr1_s.ex.tval};

  assign head_go_s       = (state_q == RUN) && !halt_i && instr0_s.valid;
  assign head_exc_s      = head_go_s && instr0_s.ex.valid;
  assign head_store_s    = head_go_s && !instr0_s.ex.valid && (instr0_s.fu == STORE);
  assign head_fence_s    = head_go_s && !instr0_s.ex.valid && (instr0_s.fu != STORE)
                           && (instr0_s.op == FENCE);
  assign fence_release_s = (state_q == FENCE_WAIT) && !halt_i && cu.no_st_pending;

  // The younger slot only rides along with a plain head commit; anything that
  // serialises (store, fence, CSR, exception) must reach port 0 first.
  assign port1_ok_s = head_go_s && !instr0_s.ex.valid
                      && (instr0_s.fu != STORE) && (instr0_s.fu != CSR)
                      && (instr0_s.op != FENCE)
                      && instr1_s.valid && !instr1_s.ex.valid
                      && (instr1_s.fu != STORE) && (instr1_s.fu != LOAD)
                      && (instr1_s.fu != CSR) && (instr1_s.op != FENCE);

  // State register, registered exception, fence pulse and retire counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      exception_q   <= '0;
      fence_flush_q <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      exception_q   <= exception_d;
      fence_flush_q <= fence_flush_d;
      instret_q     <= instret_d;
    end
  end

  // Next-state logic; a flush overrides every other transition.
  always_comb begin
    state_d       = state_q;
    exception_d   = exception_q;
    fence_flush_d = 1'b0;
    if (flush_i) begin
      state_d           = RUN;
      exception_d.valid = 1'b0;
      fence_flush_d     = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (head_exc_s) begin
            state_d     = EXC_WAIT;
            exception_d = instr0_s.ex;
          end else if (head_fence_s) begin
            if (cu.no_st_pending) begin
              fence_flush_d = 1'b1;
            end else begin
              state_d = FENCE_WAIT;
            end
          end else begin
            state_d = RUN;
          end
        end
        FENCE_WAIT: begin
          if (fence_release_s) begin
            state_d       = RUN;
            fence_flush_d = 1'b1;
          end else begin
            state_d = FENCE_WAIT;
          end
        end
        EXC_WAIT: state_d = EXC_WAIT;
        default:  state_d = RUN;
      endcase
    end
  end

  // Acknowledges, write enables and store grant.
  always_comb begin
    ack_s        = 2'b00;
    we_gpr_s     = 2'b00;
    we_fpr_s     = 2'b00;
    commit_lsu_s = 1'b0;
    if (head_exc_s) begin
      ack_s[0] = 1'b1;
    end else if (head_store_s) begin
      commit_lsu_s = 1'b1;
      ack_s[0]     = cu.commit_lsu_ready;
    end else if (head_fence_s) begin
      ack_s[0] = cu.no_st_pending;
    end else if (head_go_s) begin
      ack_s[0]    = 1'b1;
      we_fpr_s[0] = is_rd_fpr(instr0_s.op);
      we_gpr_s[0] = !is_rd_fpr(instr0_s.op) && (instr0_s.rd != 5'd0);
    end else if (fence_release_s) begin
      ack_s[0] = 1'b1;
    end else begin
      ack_s[0] = 1'b0;
    end
    if (port1_ok_s) begin
      ack_s[1]    = 1'b1;
      we_fpr_s[1] = is_rd_fpr(instr1_s.op);
      we_gpr_s[1] = !is_rd_fpr(instr1_s.op) && (instr1_s.rd != 5'd0);
    end else begin
      ack_s[1] = 1'b0;
    end
  end

  // Retired-instruction count wraps naturally at 2^64.
  always_comb begin
    instret_d = instret_q + XLEN'(ack_s[0]) + XLEN'(ack_s[1]);
  end

  assign cu.commit_ack  = ack_s;
  assign cu.we_gpr      = we_gpr_s;
  assign cu.we_fpr      = we_fpr_s;
  assign cu.commit_lsu  = commit_lsu_s;
  assign cu.waddr       = {instr1_s.rd, instr0_s.rd};
  assign cu.wdata       = {instr1_s.result, instr0_s.result};

  assign exception_o    = exception_q;
  assign fence_flush_o  = fence_flush_q;
  assign instret_o      = instret_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: dual commit, store/fence/exception sequencing,
// halt, same-rd writes, instret wrap and asynchronous reset.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            halt_i;
  logic            flush_i;
  exception_t      exception_o;
  logic            fence_flush_o;
  logic [63:0]     instret_o;
  int              checks_total  = 0;
  int              checks_passed = 0;

  always #5 clk = ~clk;

  commit_unit_if #(.NR_COMMIT_PORTS(2)) cif ();

  commit_unit #(.NR_COMMIT_PORTS(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .halt_i        (halt_i),
    .flush_i       (flush_i),
    .cu            (cif.slave),
    .exception_o   (exception_o),
    .fence_flush_o (fence_flush_o),
    .instret_o     (instret_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic scoreboard_entry_t ent(input fu_t fu, input fu_op op,
                                            input logic [4:0] rd, input logic [63:0] res);
    scoreboard_entry_t e;
    e        = '0;
    e.valid  = 1'b1;
    e.fu     = fu;
    e.op     = op;
    e.rd     = rd;
    e.result = res;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    scoreboard_entry_t e;
    rst_ni               = 1'b0;
    halt_i               = 1'b0;
    flush_i              = 1'b0;
    cif.commit_instr     = '0;
    cif.commit_lsu_ready = 1'b0;
    cif.no_st_pending    = 1'b0;
    #3;
    check("rst_ack", 64'(cif.commit_ack), 64'd0);
    check("rst_exc_valid", 64'(exception_o.valid), 64'd0);
    check("rst_fence_flush", 64'(fence_flush_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // dual ALU commit
    cif.commit_instr[0] = ent(ALU, ADD, 5'd5, 64'h11);
    cif.commit_instr[1] = ent(ALU, ADD, 5'd6, 64'h22);
    #1;
    check("dual_ack", 64'(cif.commit_ack), 64'd3);
    check("dual_we_gpr", 64'(cif.we_gpr), 64'd3);
    check("dual_we_fpr", 64'(cif.we_fpr), 64'd0);
    check("dual_waddr", 64'(cif.waddr), 64'({5'd6, 5'd5}));
    check("dual_wdata1", cif.wdata[1], 64'h22);
    tick();
    check("dual_instret", instret_o, 64'd2);

    // store waits for the store buffer
    cif.commit_instr[0] = ent(STORE, SD, 5'd0, 64'h0);
    cif.commit_instr[1] = ent(ALU, ADD, 5'd7, 64'h33);
    for (int i = 0; i < 4; i++) begin
      cif.commit_lsu_ready = (i == 3);
      #1;
      check("st_commit_lsu", 64'(cif.commit_lsu), 64'd1);
      check("st_ack", 64'(cif.commit_ack), (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    check("st_instret", instret_o, 64'd3);
    cif.commit_lsu_ready = 1'b0;
    cif.commit_instr     = '0;

    // fence with pending stores, halt blocks release
    cif.commit_instr[0] = ent(CSR, FENCE, 5'd0, 64'h0);
    #1;
    check("fence_run_ack", 64'(cif.commit_ack), 64'd0);
    tick();
    check("fence_state_wait", 64'(dut.state_q), 64'(FENCE_WAIT));
    check("fence_wait_ack", 64'(cif.commit_ack), 64'd0);
    tick();
    halt_i            = 1'b1;
    cif.no_st_pending = 1'b1;
    #1;
    check("fence_halt_ack", 64'(cif.commit_ack), 64'd0);
    tick();
    halt_i = 1'b0;
    #1;
    check("fence_release_ack", 64'(cif.commit_ack), 64'd1);
    check("fence_flush_before", 64'(fence_flush_o), 64'd0);
    tick();
    cif.commit_instr = '0;
    check("fence_flush_pulse", 64'(fence_flush_o), 64'd1);
    check("fence_instret", instret_o, 64'd4);
    tick();
    check("fence_flush_end", 64'(fence_flush_o), 64'd0);
    cif.no_st_pending = 1'b0;

    // exception on head
    e = ent(ALU, ADD, 5'd9, 64'h44);
    e.ex.valid = 1'b1;
    e.ex.cause = 64'd2;
    cif.commit_instr[0] = e;
    cif.commit_instr[1] = ent(ALU, ADD, 5'd10, 64'h55);
    #1;
    check("exc_ack", 64'(cif.commit_ack), 64'd1);
    check("exc_we_gpr", 64'(cif.we_gpr), 64'd0);
    check("exc_we_fpr", 64'(cif.we_fpr), 64'd0);
    tick();
    check("exc_valid", 64'(exception_o.valid), 64'd1);
    check("exc_cause", exception_o.cause, 64'd2);
    cif.commit_instr[0] = ent(ALU, ADD, 5'd9, 64'h44);
    #1;
    check("exc_wait_ack", 64'(cif.commit_ack), 64'd0);
    tick();
    check("exc_hold_cause", exception_o.cause, 64'd2);
    check("exc_hold_instret", instret_o, 64'd5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_exc_valid", 64'(exception_o.valid), 64'd0);
    check("flush_state", 64'(dut.state_q), 64'(RUN));
    #1;
    check("after_flush_ack", 64'(cif.commit_ack), 64'd3);
    tick();
    check("after_flush_instret", instret_o, 64'd7);

    // rd = 0 on port 0, FPU on port 1, then halt
    cif.commit_instr[0] = ent(ALU, ADD, 5'd0, 64'h66);
    cif.commit_instr[1] = ent(FPU, FADD, 5'd3, 64'h77);
    #1;
    check("fpr_ack", 64'(cif.commit_ack), 64'd3);
    check("fpr_we_gpr", 64'(cif.we_gpr), 64'd0);
    check("fpr_we_fpr", 64'(cif.we_fpr), 64'd2);
    halt_i = 1'b1;
    #1;
    check("halt_ack", 64'(cif.commit_ack), 64'd0);
    check("halt_we_fpr", 64'(cif.we_fpr), 64'd0);
    tick();
    check("halt_instret", instret_o, 64'd7);
    halt_i = 1'b0;

    // same rd on both ports
    cif.commit_instr[0] = ent(ALU, ADD, 5'd7, 64'hA);
    cif.commit_instr[1] = ent(ALU, SUB, 5'd7, 64'hB);
    #1;
    check("same_rd_we_gpr", 64'(cif.we_gpr), 64'd3);
    check("same_rd_waddr", 64'(cif.waddr), 64'({5'd7, 5'd7}));
    tick();

    // load never rides on port 1
    cif.commit_instr[1] = ent(LOAD, LD, 5'd8, 64'hC);
    #1;
    check("load_p1_ack", 64'(cif.commit_ack), 64'd1);
    tick();
    check("load_instret", instret_o, 64'd10);
    cif.commit_instr = '0;

    // instret wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.instret_q;
    #1;
    check("wrap_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    cif.commit_instr[0] = ent(ALU, ADD, 5'd1, 64'h1);
    tick();
    check("wrap_instret", instret_o, 64'd0);

    // async reset in FENCE_WAIT
    tick();
    check("pre_rst_instret", instret_o, 64'd1);
    cif.commit_instr[0] = ent(CSR, FENCE, 5'd0, 64'h0);
    tick();
    check("pre_rst_state", 64'(dut.state_q), 64'(FENCE_WAIT));
    rst_ni = 1'b0;
    #1;
    check("mid_rst_state", 64'(dut.state_q), 64'(RUN));
    check("mid_rst_instret", instret_o, 64'd0);
    check("mid_rst_ack", 64'(cif.commit_ack), 64'd0);
    check("mid_rst_fence_flush", 64'(fence_flush_o), 64'd0);
    check("mid_rst_exc_valid", 64'(exception_o.valid), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    cif.no_st_pending = 1'b1;
    #1;
    check("post_rst_fence_ack", 64'(cif.commit_ack), 64'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
